// File: rtl/bin_bcd_7seg_pkg.sv
// Shared types and constants for the binary-to-BCD 7-segment display converter.
// Holds the FSM state encoding, the active-low segment patterns (bit6=a .. bit0=g)
// and a helper that maps one BCD digit to its segment pattern.
package bin_bcd_7seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CONV = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;

  // Non-decimal codes cannot come out of a correct conversion; show them blank.
  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin_bcd_7seg_seg7_encoder.sv
// Purpose: one BCD digit plus blank flag to an active-low 7-segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module seg7_encoder
  import bin_bcd_7seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the digit so leading zeros go dark.
  always_comb begin
    seg = seg_of(bcd);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/bin_bcd_7seg.sv
// Purpose: converts a 12-bit unsigned sample to four 7-segment digits via double-dabble.
// Latency: start accepted at edge N, digits and done pulse registered at edge N+13.
// Backpressure: start is ignored while busy; no queuing, value is latched at acceptance.
module bin_bcd_7seg
  import bin_bcd_7seg_pkg::*;
#(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [6:0]       Disp1,
  output logic [6:0]       Disp2,
  output logic [6:0]       Disp3,
  output logic [6:0]       Disp4
);

  localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);
  localparam bit         BLANK_EN  = (BLANK_LZ != 0);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0][6:0]         disp_q, disp_d;

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+WIDTH-1:0]  shifted;
  logic [3:0]              blank_w;
  logic [3:0][6:0]         seg_w;

  // State register; reset forces IDLE so an in-flight conversion is abandoned.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: IDLE -> CONV on start, CONV for WIDTH edges, FIN for one edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONV;
      ST_CONV: if (cnt_q == LAST_ITER) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One double-dabble step: bump nibbles >= 5 by 3, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Leading-zero blanking: a digit goes dark only if it and every digit above it are zero.
  always_comb begin
    blank_w    = 4'b0000;
    blank_w[3] = BLANK_EN && (bcd_q[15:12] == 4'd0);
    blank_w[2] = blank_w[3] && (bcd_q[11:8] == 4'd0);
    blank_w[1] = blank_w[2] && (bcd_q[7:4] == 4'd0);
  end

  genvar g;
  generate
    for (g = 0; g < BCD_DIGITS; g++) begin : g_enc
      seg7_encoder u_enc (
        .bcd   (bcd_q[4*g +: 4]),
        .blank (blank_w[g]),
        .seg   (seg_w[g])
      );
    end
  endgenerate

  // Datapath and output updates per state; digits only move on the FIN edge.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    disp_d = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d  = value;
          bcd_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
        end
      end
      ST_CONV: begin
        bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
        bin_d = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 4'd1;
      end
      ST_FIN: begin
        disp_d = seg_w;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: busy_d = 1'b0;
    endcase
  end

  // Datapath registers; reset blanks the display and clears the converter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      disp_q <= {4{SEG_BLANK}};
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      disp_q <= disp_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Disp1 = disp_q[0];
  assign Disp2 = disp_q[1];
  assign Disp3 = disp_q[2];
  assign Disp4 = disp_q[3];

endmodule

// File: tb/tb_bin_bcd_7seg.sv
// Directed bench for bin_bcd_7seg: one instance with leading-zero blanking, one without.
// Both share stimulus; expected segment codes are hand-computed constants.
module tb_bin_bcd_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] value;

  logic        busy, done, busy_nb, done_nb;
  logic [6:0]  d1, d2, d3, d4;
  logic [6:0]  n1, n2, n3, n4;

  int n_chk  = 0;
  int n_fail = 0;

  int done_cyc, n_done, n_done_nb, n_busy, n_ovl, n_chg;

  always #5 clk = ~clk;

  bin_bcd_7seg #(.WIDTH(12), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done),
    .Disp1(d1), .Disp2(d2), .Disp3(d3), .Disp4(d4)
  );

  bin_bcd_7seg #(.WIDTH(12), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_nb), .done(done_nb),
    .Disp1(n1), .Disp2(n2), .Disp3(n3), .Disp4(n4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected displays given Disp4..Disp1 for the blanking and non-blanking instances.
  task automatic chk_disp(input string tag,
                          input logic [6:0] e4, input logic [6:0] e3,
                          input logic [6:0] e2, input logic [6:0] e1,
                          input logic [6:0] f4, input logic [6:0] f3,
                          input logic [6:0] f2, input logic [6:0] f1);
    chk({tag, "_blz"}, {4'h0, d4, d3, d2, d1}, {4'h0, e4, e3, e2, e1});
    chk({tag, "_nbz"}, {4'h0, n4, n3, n2, n1}, {4'h0, f4, f3, f2, f1});
  endtask

  // kind 0: plain; kind 1: second start with 999 at edge N+5; kind 2: reset at edge N+6.
  task automatic run_conv(input logic [11:0] val, input int kind);
    logic [27:0] prev;
    value = val;
    start = 1'b1;
    tick();                       // edge N
    start     = 1'b0;
    done_cyc  = -1;
    n_done    = 0;
    n_done_nb = 0;
    n_busy    = busy ? 1 : 0;
    n_ovl     = 0;
    n_chg     = 0;
    prev      = {d4, d3, d2, d1};
    for (int k = 1; k <= 16; k++) begin
      if (kind == 1 && k == 5) begin start = 1'b1; value = 12'd999; end
      if (kind == 2 && k == 6) rst = 1'b1;
      tick();
      start = 1'b0;
      rst   = 1'b0;
      if (k == 3) value = 12'd2222;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_nb) n_done_nb++;
      if (busy) n_busy++;
      if (busy && done) n_ovl++;
      if ({d4, d3, d2, d1} !== prev && !done) n_chg++;
      prev = {d4, d3, d2, d1};
    end
  endtask

  task automatic chk_timing(input string tag);
    chk({tag, "_latency"}, done_cyc, 13);
    chk({tag, "_busy_cycles"}, n_busy, 13);
    chk({tag, "_done_count"}, n_done, 1);
    chk({tag, "_done_count_nb"}, n_done_nb, 1);
    chk({tag, "_busy_done_overlap"}, n_ovl, 0);
    chk({tag, "_disp_hold"}, n_chg, 0);
  endtask

  initial begin
    int first_done, second_done, held_done;
    rst   = 1'b1;
    start = 1'b0;
    value = 12'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk_disp("reset_disp", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Start asserted with rst still high must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_over_start_busy", busy, 0);

    run_conv(12'd0, 0);
    chk_timing("v0");
    chk_disp("v0", 7'h7F, 7'h7F, 7'h7F, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01);

    run_conv(12'd4095, 0);
    chk_timing("v4095");
    chk_disp("v4095", 7'h4C, 7'h01, 7'h04, 7'h24, 7'h4C, 7'h01, 7'h04, 7'h24);

    run_conv(12'd1234, 0);
    chk_disp("v1234", 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h4F, 7'h12, 7'h06, 7'h4C);

    run_conv(12'd7, 0);
    chk_timing("v7");
    chk_disp("v7", 7'h7F, 7'h7F, 7'h7F, 7'h0F, 7'h01, 7'h01, 7'h01, 7'h0F);

    run_conv(12'd50, 0);
    chk_disp("v50", 7'h7F, 7'h7F, 7'h24, 7'h01, 7'h01, 7'h01, 7'h24, 7'h01);

    run_conv(12'd305, 0);
    chk_disp("v305", 7'h7F, 7'h06, 7'h01, 7'h24, 7'h01, 7'h06, 7'h01, 7'h24);

    run_conv(12'd2468, 0);
    chk_disp("v2468", 7'h12, 7'h4C, 7'h20, 7'h00, 7'h12, 7'h4C, 7'h20, 7'h00);

    // Restart while busy is dropped; result reflects the first value.
    run_conv(12'd1234, 1);
    chk_timing("ignore");
    chk_disp("ignore", 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h4F, 7'h12, 7'h06, 7'h4C);

    // Reset mid-conversion aborts with no done and blanks the display.
    run_conv(12'd1234, 2);
    chk("abort_done_count", n_done, 0);
    chk("abort_busy_cycles", n_busy, 6);
    chk("abort_busy_after", busy, 0);
    chk_disp("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    run_conv(12'd3000, 0);
    chk_timing("v3000");
    chk_disp("v3000", 7'h06, 7'h01, 7'h01, 7'h01, 7'h06, 7'h01, 7'h01, 7'h01);

    // Start held high: conversions back to back every 14 cycles.
    value = 12'd42;
    start = 1'b1;
    tick();                       // edge N
    first_done  = -1;
    second_done = -1;
    held_done   = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done) begin
        held_done++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
    end
    start = 1'b0;
    repeat (16) tick();
    chk("held_first_done", first_done, 13);
    chk("held_second_done", second_done, 27);
    chk("held_done_count", held_done, 2);
    chk("held_idle_after", busy, 0);
    chk_disp("v42", 7'h7F, 7'h7F, 7'h4C, 7'h12, 7'h01, 7'h01, 7'h4C, 7'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
